seq_padlock: RTL and testbench
==============================

SEQ_PADLOCK -- requirements
Module: seq_padlock

Interface
REQ-001 Parameter DIGIT_W, default 4: width of one code digit in bits.
REQ-002 Parameter CODE_LEN, default 4: number of digits in the code, at least 2.
REQ-003 Parameter DEFAULT_CODE, default 16'h1234: reset code, DIGIT_W*CODE_LEN bits; digit 0 is the most significant DIGIT_W bits and is entered first.
REQ-004 Parameter MAX_TRIES, default 3: consecutive failed attempts that trigger lockout.
REQ-005 Parameter LOCKOUT_CYCLES, default 16: lockout duration in clocks.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 digit_i  in  DIGIT_W  digit value, sampled when enter_i is 1.
REQ-009 enter_i  in  1  one-cycle digit strobe; one digit is consumed per high cycle.
REQ-010 clear_i  in  1  abandons the partial entry.
REQ-011 lock_i  in  1  relock request.
REQ-012 prog_i  in  1  program-mode request, level-sensitive.
REQ-013 unlocked_o  out  1  state is UNLOCKED.
REQ-014 prog_o  out  1  state is PROGRAM.
REQ-015 lockout_o  out  1  state is LOCKOUT.
REQ-016 err_o  out  1  one-cycle pulse on a failed attempt.
REQ-017 done_o  out  1  one-cycle pulse when a new code is committed.
REQ-018 progress_o  out  $clog2(CODE_LEN+1)  digits accepted in the current entry.

Function
REQ-019 The state machine SHALL have the states LOCKED, UNLOCKED, PROGRAM and LOCKOUT; every output is registered.
REQ-020 LOCKED: each enter_i SHALL compare digit_i with code[idx], OR any mismatch into a sticky flag, increment idx and increment progress_o; no result is given before the last digit.
REQ-021 On the last digit with no mismatch, the next state SHALL be UNLOCKED, with unlocked_o high one cycle after the strobe; the fail counter and idx clear.
REQ-022 On the last digit with any mismatch, err_o SHALL pulse one cycle after the strobe, and idx, the flag and progress_o clear; the fail counter increments, saturating at MAX_TRIES.
REQ-023 clear_i in LOCKED or PROGRAM SHALL zero idx, the flag and progress_o, and does not count as a failure; clear_i wins over enter_i in the same cycle and that digit is dropped.
REQ-024 UNLOCKED: lock_i SHALL return the block to LOCKED next cycle; prog_i SHALL enter PROGRAM next cycle; lock_i has priority over prog_i.
REQ-025 PROGRAM: each enter_i SHALL write digit_i into shadow[idx]; after CODE_LEN digits the shadow is copied to code, done_o pulses, and the next state is UNLOCKED.
REQ-026 Deasserting prog_i before commit SHALL abort to UNLOCKED with code unchanged and progress_o cleared.
REQ-027 enter_i, clear_i, lock_i and prog_i SHALL be ignored in any state not listed for them.
REQ-028 idx SHALL never exceed CODE_LEN-1; it wraps to 0 after the last digit of an attempt or programming pass.

Reset
REQ-029 While rst_n is low: state LOCKED, code = DEFAULT_CODE, shadow = 0, idx = 0, flag = 0, fail and lockout counters = 0, all outputs 0.
REQ-030 Reset during an entry, programming pass or lockout SHALL abandon it immediately; a code committed earlier is lost and reverts to DEFAULT_CODE.

Configuration
REQ-031 Macro SEQ_PADLOCK_LOCKOUT_EN defined: reaching MAX_TRIES failures enters LOCKOUT for exactly LOCKOUT_CYCLES clocks, with all inputs ignored; the block then returns to LOCKED with the fail counter cleared.
REQ-032 Macro undefined: the fail and lockout counters are not built, lockout_o is tied to 0, and failed attempts only pulse err_o.

Structure
REQ-033 Package seq_padlock_pkg SHALL hold the state enum and the idx/progress width function.
REQ-034 Code storage (code and shadow registers, commit, per-digit read mux) SHALL be sub-module seq_padlock_code_reg; the FSM and counters stay in seq_padlock.

Verification
REQ-035 After reset, enter 1,2,3,4 -> unlocked_o = 1 one cycle after the 4th strobe; progress_o reads 1,2,3,0.
REQ-036 Enter 1,2,3,5 three times (LOCKOUT_EN defined) -> err_o pulses 3 times, lockout_o high for 16 cycles, strobes ignored during lockout, then 1,2,3,4 unlocks.
REQ-037 Enter 1,2, then clear_i together with enter_i of 9, then 1,2,3,4 -> unlock with no err_o.
REQ-038 While unlocked, prog_i high, enter A,B,C,D -> done_o pulses; lock_i; then 1,2,3,4 gives err_o and A,B,C,D unlocks.
REQ-039 While unlocked, prog_i high, enter A,B, drop prog_i -> UNLOCKED, code still 1234, done_o never asserted.
REQ-040 Assert rst_n low mid-lockout after a code was programmed -> all outputs 0 and 1,2,3,4 unlocks.

Source files
------------

// File: rtl/seq_padlock_pkg.sv
// seq_padlock_pkg: shared state encoding and counter width helper for the padlock.
package seq_padlock_pkg;
  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_PROGRAM, S_LOCKOUT} state_e;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_padlock_code_reg.sv
// seq_padlock_code_reg: active code and programming shadow, digit 0 in the MSBs.
module seq_padlock_code_reg #(
  parameter int DIGIT_W = 4,
  parameter int CODE_LEN = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_i,
  input  logic               commit_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);
  logic [0:CODE_LEN-1][DIGIT_W-1:0] code_q, code_d, shadow_q, shadow_d;
  // The commit cycle also carries the last digit, so the code takes the updated shadow.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_i) shadow_d[idx_i] = digit_i;
    code_d = commit_i ? shadow_d : code_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
    end else begin
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end
  assign digit_o = code_q[idx_i];
endmodule

// File: rtl/seq_padlock.sv
// seq_padlock: sequential code lock FSM with programming mode.
// Define SEQ_PADLOCK_LOCKOUT_EN to build the failed-attempt lockout.
module seq_padlock
  import seq_padlock_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int CODE_LEN = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W-1:0]            digit_i,
  input  logic                          enter_i,
  input  logic                          clear_i,
  input  logic                          lock_i,
  input  logic                          prog_i,
  output logic                          unlocked_o,
  output logic                          prog_o,
  output logic                          lockout_o,
  output logic                          err_o,
  output logic                          done_o,
  output logic [cnt_w(CODE_LEN+1)-1:0]  progress_o
);
  localparam int IDX_W = cnt_w(CODE_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CODE_LEN - 1);
  if (CODE_LEN < 2 || MAX_TRIES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
    $error("seq_padlock: invalid parameters");
  end
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic flag_q, flag_d, err_d, done_d, wr, commit, unlocked_d, prog_d, lockout_d;
  logic [DIGIT_W-1:0] code_digit;
`ifdef SEQ_PADLOCK_LOCKOUT_EN
  localparam int FAIL_W = cnt_w(MAX_TRIES + 1);
  localparam int CNT_W = cnt_w(LOCKOUT_CYCLES);
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif
  seq_padlock_code_reg #(
    .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEFAULT_CODE), .IDX_W(IDX_W)
  ) u_code (
    .clk(clk), .rst_n(rst_n), .wr_i(wr), .commit_i(commit),
    .idx_i(idx_q), .digit_i(digit_i), .digit_o(code_digit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOCKED;
      idx_q      <= '0;
      flag_q     <= 1'b0;
      unlocked_o <= 1'b0;
      prog_o     <= 1'b0;
      lockout_o  <= 1'b0;
      err_o      <= 1'b0;
      done_o     <= 1'b0;
`ifdef SEQ_PADLOCK_LOCKOUT_EN
      fail_q     <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      flag_q     <= flag_d;
      unlocked_o <= unlocked_d;
      prog_o     <= prog_d;
      lockout_o  <= lockout_d;
      err_o      <= err_d;
      done_o     <= done_d;
`ifdef SEQ_PADLOCK_LOCKOUT_EN
      fail_q     <= fail_d;
      cnt_q      <= cnt_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flag_d  = flag_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    wr      = 1'b0;
    commit  = 1'b0;
`ifdef SEQ_PADLOCK_LOCKOUT_EN
    fail_d  = fail_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_LOCKED:
        if (clear_i) begin
          idx_d  = '0;
          flag_d = 1'b0;
        end else if (enter_i) begin
          idx_d  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
          flag_d = (idx_q == LAST) ? 1'b0 : flag_q | (digit_i != code_digit);
          if (idx_q == LAST && !flag_q && digit_i == code_digit) begin
            state_d = S_UNLOCKED;
`ifdef SEQ_PADLOCK_LOCKOUT_EN
            fail_d  = '0;
`endif
          end else if (idx_q == LAST) begin
            err_d = 1'b1;
`ifdef SEQ_PADLOCK_LOCKOUT_EN
            fail_d = (fail_q == FAIL_W'(MAX_TRIES)) ? fail_q : fail_q + 1'b1;
            if (fail_d == FAIL_W'(MAX_TRIES)) begin
              state_d = S_LOCKOUT;
              cnt_d   = '0;
            end
`endif
          end
        end
      S_UNLOCKED: begin
        state_d = lock_i ? S_LOCKED : prog_i ? S_PROGRAM : S_UNLOCKED;
        idx_d   = '0;
      end
      S_PROGRAM:
        if (!prog_i) begin
          state_d = S_UNLOCKED;
          idx_d   = '0;
        end else if (clear_i) begin
          idx_d = '0;
        end else if (enter_i) begin
          wr      = 1'b1;
          commit  = idx_q == LAST;
          done_d  = idx_q == LAST;
          idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
          state_d = (idx_q == LAST) ? S_UNLOCKED : S_PROGRAM;
        end
      default: begin
`ifdef SEQ_PADLOCK_LOCKOUT_EN
        state_d = (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) ? S_LOCKED : S_LOCKOUT;
        fail_d  = (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) ? '0 : fail_q;
        cnt_d   = (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
`else
        state_d = S_LOCKED;
`endif
      end
    endcase
  end
  always_comb begin
    unlocked_d = state_d == S_UNLOCKED;
    prog_d     = state_d == S_PROGRAM;
`ifdef SEQ_PADLOCK_LOCKOUT_EN
    lockout_d  = state_d == S_LOCKOUT;
`else
    lockout_d  = 1'b0;
`endif
  end
  assign progress_o = ($bits(progress_o))'(idx_q);
endmodule

// File: tb/tb_seq_padlock.sv
// tb_seq_padlock: scoreboard bench comparing every cycle against a behavioural lock model.
module tb_seq_padlock;
  logic clk = 0, rst_n = 1, enter_i = 0, clear_i = 0, lock_i = 0, prog_i = 0;
  logic [3:0] digit_i = 0;
  logic unlocked_o, prog_o, lockout_o, err_o, done_o;
  logic [2:0] progress_o;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int m_state, m_fails, m_left;
  int m_code[4];
  int m_entry[$];

  always #5 clk = ~clk;

  seq_padlock dut (
    .clk(clk), .rst_n(rst_n), .digit_i(digit_i), .enter_i(enter_i), .clear_i(clear_i),
    .lock_i(lock_i), .prog_i(prog_i), .unlocked_o(unlocked_o), .prog_o(prog_o),
    .lockout_o(lockout_o), .err_o(err_o), .done_o(done_o), .progress_o(progress_o)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (unl,prog,lko,err,done,progress[2:0])", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {unlocked_o, prog_o, lockout_o, err_o, done_o, progress_o};
  endfunction

  task automatic m_reset();
    m_state = 0; m_fails = 0; m_left = 0;
    m_code = '{1, 2, 3, 4};
    m_entry.delete();
  endtask

  task automatic model(input bit en, input int d, input bit clr, input bit lk, input bit pg);
    bit err = 0, done = 0, ok;
    case (m_state)
      0: if (clr) m_entry.delete();
         else if (en) begin
           m_entry.push_back(d);
           if (m_entry.size() == 4) begin
             ok = 1;
             foreach (m_entry[i]) if (m_entry[i] != m_code[i]) ok = 0;
             m_entry.delete();
             if (ok) begin m_state = 1; m_fails = 0; end
             else begin
               err = 1;
`ifdef SEQ_PADLOCK_LOCKOUT_EN
               m_fails++;
               if (m_fails >= 3) begin m_state = 3; m_left = 16; end
`endif
             end
           end
         end
      1: if (lk) m_state = 0; else if (pg) begin m_state = 2; m_entry.delete(); end
      2: if (!pg) begin m_state = 1; m_entry.delete(); end
         else if (clr) m_entry.delete();
         else if (en) begin
           m_entry.push_back(d);
           if (m_entry.size() == 4) begin
             foreach (m_entry[i]) m_code[i] = m_entry[i];
             m_entry.delete();
             done = 1; m_state = 1;
           end
         end
      default: begin
        m_left--;
        if (m_left == 0) begin m_state = 0; m_fails = 0; end
      end
    endcase
    exp_q.push_back({m_state == 1, m_state == 2, m_state == 3, err, done, 3'(m_entry.size())});
  endtask

  task automatic step(input bit en, input logic [3:0] d, input bit clr, input bit lk, input bit pg,
                      input string tag);
    enter_i = en; digit_i = d; clear_i = clr; lock_i = lk; prog_i = pg;
    model(en, int'(d), clr, lk, pg);
    @(posedge clk); #1;
    if (exp_q.size() == 0) check({tag, "_noexp"}, outs(), 8'hff);
    else check(tag, outs(), exp_q.pop_front());
  endtask

  task automatic code4(input logic [15:0] c, input bit pg, input string tag);
    for (int i = 0; i < 4; i++) step(1, c[15-4*i -: 4], 0, 0, pg, tag);
  endtask

  task automatic do_reset(input string tag);
    enter_i = 0; clear_i = 0; lock_i = 0; prog_i = 0;
    rst_n = 0;
    m_reset();
    exp_q.push_back(8'h00);
    #1;
    check(tag, outs(), exp_q.pop_front());
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_held"}, outs(), 8'h00);
    rst_n = 1;
  endtask

  initial begin
    bit pg = 0;
    logic [3:0] d;
    #2;
    do_reset("reset");
    code4(16'h1234, 0, "open1234");
    check("unlocked_after_1234", {7'b0, unlocked_o}, 8'h01);
    step(0, 0, 0, 1, 0, "relock");
    for (int k = 0; k < 3; k++) code4(16'h1235, 0, "bad1235");
    for (int k = 0; k < 16; k++) step(1, 4'h1, 0, 0, 0, "lockout_strobe");
    step(0, 0, 1, 0, 0, "post_lockout_clear");
    code4(16'h1234, 0, "open_after_lockout");
    step(0, 0, 0, 1, 0, "relock2");
    step(1, 4'h1, 0, 0, 0, "partial1");
    step(1, 4'h2, 0, 0, 0, "partial2");
    step(1, 4'h9, 1, 0, 0, "clear_wins");
    code4(16'h1234, 0, "open_after_clear");
    step(0, 0, 0, 0, 1, "enter_prog_abort");
    step(1, 4'hA, 0, 0, 1, "prog_a");
    step(1, 4'hB, 0, 0, 1, "prog_b");
    step(0, 0, 0, 0, 0, "prog_drop");
    step(0, 0, 0, 1, 0, "relock3");
    code4(16'h1234, 0, "code_unchanged");
    step(0, 0, 0, 0, 1, "enter_prog");
    code4(16'hABCD, 1, "prog_abcd");
    step(0, 0, 0, 1, 0, "relock4");
    code4(16'h1234, 0, "old_code_fails");
    code4(16'hABCD, 0, "new_code_opens");
    step(0, 0, 0, 1, 0, "relock5");
    for (int k = 0; k < 3; k++) code4(16'h1235, 0, "bad_before_reset");
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, "mid_lockout");
    do_reset("reset_mid_lockout");
    code4(16'h1234, 0, "default_after_reset");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) pg = ~pg;
      d = 4'($urandom_range(0, 15));
      if (m_state == 0 && $urandom_range(0, 3) != 0) d = 4'(m_code[m_entry.size()]);
      step(1'($urandom_range(0, 1)), d, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, pg,
           "random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
